// File: rtl/uart_pkg.sv
// Shared UART constants and the divisor payload used between the register file and the baud generator.
package uart_pkg;

   localparam int unsigned OVS_LOG2_DEF = 4;
   localparam int unsigned INT_W_DEF    = 16;
   localparam int unsigned FRAC_W_DEF   = 4;
   localparam int unsigned DIV_MIN      = 2;

   typedef struct packed {
      logic [INT_W_DEF-1:0]  ival;
      logic [FRAC_W_DEF-1:0] fval;
   } baud_div_t;

endpackage

// File: rtl/uart_frac_counter.sv
// Fractional-N base counter: holds shadow/active divisor and emits the registered oversample tick.
module uart_frac_counter #(
   parameter int unsigned INT_W  = 16,
   parameter int unsigned FRAC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              wr,
   input  logic [INT_W-1:0]  wr_int,
   input  logic [FRAC_W-1:0] wr_frac,
   output logic              tick_os
);

   typedef struct packed {
      logic [INT_W-1:0]  ival;
      logic [FRAC_W-1:0] fval;
   } divisor_t;

   divisor_t            act_q, act_d, shadow_q, shadow_d, wr_div, load_div;
   logic                pend_q, pend_d;
   logic                en_q;
   logic [INT_W-1:0]    cnt_q, cnt_d;
   logic [FRAC_W-1:0]   acc_q, acc_d;
   logic [FRAC_W:0]     sum;
   logic                tick_d;
   logic                running;

   assign wr_div   = {wr_int, wr_frac};
   assign running  = en && (act_q.ival != '0);
   // A pending shadow takes over at the terminal count, so the reload uses it.
   assign load_div = pend_q ? shadow_q : act_q;
   assign sum      = {1'b0, acc_q} + {1'b0, load_div.fval};

   always_comb begin
      act_d    = act_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      tick_d   = 1'b0;

      if (wr) begin
         shadow_d = wr_div;
         if (!running) begin
            act_d  = wr_div;
            pend_d = 1'b0;
         end else begin
            pend_d = 1'b1;
         end
      end else if (pend_q && !running) begin
         act_d  = shadow_q;
         pend_d = 1'b0;
      end

      if (!en) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (!running) begin
         if (wr) begin
            cnt_d = wr_div.ival - INT_W'(1);
            acc_d = '0;
         end
      end else if (!en_q) begin
         // Restart after enable rises: a full integer period before the first tick.
         cnt_d = act_q.ival - INT_W'(1);
         acc_d = '0;
      end else if (cnt_q == '0) begin
         tick_d = 1'b1;
         if (pend_q) begin
            act_d  = shadow_q;
            pend_d = wr;
         end
         acc_d = sum[FRAC_W-1:0];
         cnt_d = load_div.ival - INT_W'(1) + INT_W'(sum[FRAC_W]);
      end else begin
         cnt_d = cnt_q - INT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_q    <= '0;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         en_q     <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         tick_os  <= 1'b0;
      end else begin
         act_q    <= act_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         en_q     <= en;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         tick_os  <= tick_d;
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: fractional base tick plus TX bit tick and resynchronisable RX mid-bit strobe.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned INT_W    = INT_W_DEF,
   parameter int unsigned FRAC_W   = FRAC_W_DEF,
   parameter int unsigned OVS_LOG2 = OVS_LOG2_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [INT_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_wr,
   input  logic              rx_resync,
   output logic              tick_os,
   output logic              tx_tick,
   output logic              rx_sample,
   output logic              cfg_err
);

   localparam int unsigned OVS = 2 ** OVS_LOG2;

   logic                div_bad;
   logic                wr_ok;
   logic [OVS_LOG2-1:0] tx_os;
   logic [OVS_LOG2-1:0] rx_os;

   assign div_bad = div_int < INT_W'(DIV_MIN);
   assign wr_ok   = div_wr && !div_bad;

   uart_frac_counter #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
   ) u_frac_counter (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .wr      (wr_ok),
      .wr_int  (div_int),
      .wr_frac (div_frac),
      .tick_os (tick_os)
   );

   // Sticky until the next divisor write; survives enable going low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_err <= 1'b0;
      end else if (div_wr) begin
         cfg_err <= div_bad;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_os <= '0;
         rx_os <= '0;
      end else if (!en) begin
         tx_os <= '0;
         rx_os <= '0;
      end else begin
         if (tick_os) begin
            tx_os <= tx_os + OVS_LOG2'(1);
         end
         if (rx_resync) begin
            rx_os <= '0;
         end else if (tick_os) begin
            rx_os <= rx_os + OVS_LOG2'(1);
         end
      end
   end

   // Strobes ride on tick_os in the same cycle; resync masks the RX strobe it collides with.
   assign tx_tick   = tick_os && (tx_os == OVS_LOG2'(OVS - 1));
   assign rx_sample = tick_os && !rx_resync && (rx_os == OVS_LOG2'(OVS / 2 - 1));

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen at default parameters (INT_W=16, FRAC_W=4, OVS=16).
module tb_uart_baud_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] div_int;
   logic [3:0]  div_frac;
   logic        div_wr;
   logic        rx_resync;
   logic        tick_os;
   logic        tx_tick;
   logic        rx_sample;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_baud_gen dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .div_int   (div_int),
      .div_frac  (div_frac),
      .div_wr    (div_wr),
      .rx_resync (rx_resync),
      .tick_os   (tick_os),
      .tx_tick   (tx_tick),
      .rx_sample (rx_sample),
      .cfg_err   (cfg_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle divisor write; returns just after the capturing edge.
   task automatic write_div(input int i, input int f);
      div_int  = 16'(i);
      div_frac = 4'(f);
      div_wr   = 1'b1;
      step();
      div_wr   = 1'b0;
   endtask

   // Load with en low, then raise en; returns just after the restart edge.
   task automatic restart(input int i, input int f);
      en = 1'b0;
      step();
      write_div(i, f);
      en = 1'b1;
      step();
   endtask

   // Steps to the next tick_os; dt = steps taken, -1 if none within the bound.
   task automatic next_tick(output int dt);
      dt = -1;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (tick_os === 1'b1) begin
            dt = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1; en = 1'b0; div_int = '0; div_frac = '0; div_wr = 1'b0; rx_resync = 1'b0;
      #12;
      checks++; if (tick_os !== 1'b0) begin errors++; $display("FAIL reset_tick_os got %b exp 0", tick_os); end
      checks++; if (tx_tick !== 1'b0) begin errors++; $display("FAIL reset_tx_tick got %b exp 0", tx_tick); end
      checks++; if (rx_sample !== 1'b0) begin errors++; $display("FAIL reset_rx_sample got %b exp 0", rx_sample); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
      step();
      rst = 1'b0;
      en  = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tick_os !== 1'b0) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL stopped_no_ticks got %0d exp 0", n); end
   endtask

   task automatic test_basic();
      int n = 0, last = 0, first = -1, bad = 0, strays = 0;
      int rx1 = -1, rx2 = -1, tx1 = -1, tx2 = -1;
      write_div(4, 0);
      for (int c = 1; c <= 140; c++) begin
         step();
         if (tick_os === 1'b1) begin
            n++;
            if (n == 1) first = c;
            else if (c - last != 4) bad++;
            last = c;
         end
         if ((rx_sample === 1'b1 || tx_tick === 1'b1) && tick_os !== 1'b1) strays++;
         if (rx_sample === 1'b1) begin if (rx1 < 0) rx1 = c; else if (rx2 < 0) rx2 = c; end
         if (tx_tick === 1'b1) begin if (tx1 < 0) tx1 = c; else if (tx2 < 0) tx2 = c; end
      end
      checks++; if (first != 4) begin errors++; $display("FAIL basic_first_tick got %0d exp 4", first); end
      checks++; if (n != 35) begin errors++; $display("FAIL basic_tick_count got %0d exp 35", n); end
      checks++; if (bad != 0) begin errors++; $display("FAIL basic_period got %0d bad exp 0", bad); end
      checks++; if (strays != 0) begin errors++; $display("FAIL basic_strobe_align got %0d exp 0", strays); end
      checks++; if (rx1 != 32) begin errors++; $display("FAIL basic_rx1 got %0d exp 32", rx1); end
      checks++; if (rx2 != 96) begin errors++; $display("FAIL basic_rx2 got %0d exp 96", rx2); end
      checks++; if (tx1 != 64) begin errors++; $display("FAIL basic_tx1 got %0d exp 64", tx1); end
      checks++; if (tx2 != 128) begin errors++; $display("FAIL basic_tx2 got %0d exp 128", tx2); end
   endtask

   task automatic test_frac();
      int t[34];
      int n = 0, odd = 0;
      restart(4, 8);
      for (int c = 1; c <= 200 && n < 34; c++) begin
         step();
         if (tick_os === 1'b1) begin
            t[n] = c;
            n++;
         end
      end
      checks++; if (n != 34) begin errors++; $display("FAIL frac_tick_count got %0d exp 34", n); end
      else begin
         for (int k = 1; k < 34; k++) if (t[k] - t[k-1] != 4 && t[k] - t[k-1] != 5) odd++;
         checks++; if (t[0] != 4) begin errors++; $display("FAIL frac_first got %0d exp 4", t[0]); end
         checks++; if (t[1] - t[0] != 4) begin errors++; $display("FAIL frac_p2 got %0d exp 4", t[1] - t[0]); end
         checks++; if (t[2] - t[1] != 5) begin errors++; $display("FAIL frac_p3 got %0d exp 5", t[2] - t[1]); end
         checks++; if (t[33] - t[1] != 144) begin errors++; $display("FAIL frac_span32 got %0d exp 144", t[33] - t[1]); end
         checks++; if (odd != 0) begin errors++; $display("FAIL frac_period_range got %0d exp 0", odd); end
      end
   endtask

   task automatic test_midwrite();
      int dt;
      int seen = -1;
      restart(10, 0);
      next_tick(dt);
      checks++; if (dt != 10) begin errors++; $display("FAIL mid_first got %0d exp 10", dt); end
      for (int c = 1; c <= 30; c++) begin
         step();
         div_wr = 1'b0;
         if (c == 4) begin
            div_int = 16'd3; div_frac = 4'd0; div_wr = 1'b1;
         end
         if (tick_os === 1'b1) begin
            seen = c;
            break;
         end
      end
      checks++; if (seen != 10) begin errors++; $display("FAIL mid_old_period got %0d exp 10", seen); end
      for (int k = 0; k < 3; k++) begin
         next_tick(dt);
         checks++; if (dt != 3) begin errors++; $display("FAIL mid_new_period%0d got %0d exp 3", k, dt); end
      end
   endtask

   task automatic test_cfg_err();
      int dt;
      write_div(1, 0);
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set got %b exp 1", cfg_err); end
      next_tick(dt);
      next_tick(dt);
      checks++; if (dt != 3) begin errors++; $display("FAIL cfg_rate_kept got %0d exp 3", dt); end
      write_div(6, 0);
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clr got %b exp 0", cfg_err); end
      next_tick(dt);
      checks++; if (dt != 2) begin errors++; $display("FAIL cfg_old_finish got %0d exp 2", dt); end
      next_tick(dt);
      checks++; if (dt != 6) begin errors++; $display("FAIL cfg_new_rate got %0d exp 6", dt); end
   endtask

   task automatic test_resync();
      int n = 0, rx_first = -1, rx_a = -1, rx_b = -1, txn = 0, tx_last = -1;
      restart(4, 0);
      for (int c = 1; c <= 250 && n < 48; c++) begin
         step();
         rx_resync = 1'b0;
         if (tick_os === 1'b1) begin
            n++;
            if (n == 24) begin
               rx_resync = 1'b1;
               #1;
               checks++; if (rx_sample !== 1'b0) begin errors++; $display("FAIL resync_suppress got %b exp 0", rx_sample); end
               checks++; if (tick_os !== 1'b1) begin errors++; $display("FAIL resync_tick_kept got %b exp 1", tick_os); end
            end
            if (rx_sample === 1'b1) begin
               if (n < 24 && rx_first < 0) rx_first = n;
               else if (n > 24 && rx_a < 0) rx_a = n;
               else if (n > 24 && rx_b < 0) rx_b = n;
            end
            if (tx_tick === 1'b1) begin
               txn++;
               tx_last = n;
            end
         end
      end
      rx_resync = 1'b0;
      checks++; if (rx_first != 8) begin errors++; $display("FAIL resync_rx_pre got %0d exp 8", rx_first); end
      checks++; if (rx_a != 32) begin errors++; $display("FAIL resync_rx_next got %0d exp 32", rx_a); end
      checks++; if (rx_b != 48) begin errors++; $display("FAIL resync_rx_after got %0d exp 48", rx_b); end
      checks++; if (txn != 3 || tx_last != 48) begin errors++; $display("FAIL resync_tx got %0d/%0d exp 3/48", txn, tx_last); end
   endtask

   task automatic test_en_toggle();
      int dt, n;
      restart(4, 0);
      next_tick(dt);
      step();
      step();
      en = 1'b0;
      n = 0;
      for (int i = 0; i < 7; i++) begin
         step();
         if (tick_os !== 1'b0 || tx_tick !== 1'b0 || rx_sample !== 1'b0) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL en_low_quiet got %0d exp 0", n); end
      en = 1'b1;
      step();
      next_tick(dt);
      checks++; if (dt != 4) begin errors++; $display("FAIL en_restart got %0d exp 4", dt); end
   endtask

   task automatic test_rst();
      int dt, n;
      write_div(0, 0);
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rst_pre_cfg_err got %b exp 1", cfg_err); end
      next_tick(dt);
      #2 rst = 1'b1;
      #1;
      checks++; if (tick_os !== 1'b0) begin errors++; $display("FAIL rst_async_tick got %b exp 0", tick_os); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_async_cfg_err got %b exp 0", cfg_err); end
      step();
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (tick_os !== 1'b0) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL rst_divisor_lost got %0d exp 0", n); end
      write_div(5, 0);
      next_tick(dt);
      checks++; if (dt != 5) begin errors++; $display("FAIL rst_reload got %0d exp 5", dt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_frac();
      test_midwrite();
      test_cfg_err();
      test_resync();
      test_en_toggle();
      test_rst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
